proto_sequencer: RTL and testbench

PROTO_SEQUENCER -- requirements
Module: proto_sequencer

---
 rtl/proto_sequencer_if.sv | 29 ++
 rtl/proto_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_proto_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proto_sequencer_if.sv
// Byte-stream and register-bus signals between proto_sequencer (master) and its
// receive/transmit front end and register file (slave).
interface proto_sequencer_if;
   logic [7:0] in_rx_data;
   logic       rx_done;
   logic       tx_done;
   logic       rx_continue;
   logic       tx_continue;
   logic [7:0] out_tx_data;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_rdata;
   logic       out_busy;
   logic [7:0] out_err_cnt;

   modport master (
      input  in_rx_data, rx_done, tx_done, reg_rdata,
      output rx_continue, tx_continue, out_tx_data, reg_addr, reg_wdata,
             reg_wr, reg_rd, out_busy, out_err_cnt
   );

   modport slave (
      output in_rx_data, rx_done, tx_done, reg_rdata,
      input  rx_continue, tx_continue, out_tx_data, reg_addr, reg_wdata,
             reg_wr, reg_rd, out_busy, out_err_cnt
   );
endinterface

// File: rtl/proto_sequencer.sv
// Frame parser turning opcode/address/length byte frames into register writes and reads,
// returning read data or a status byte, with a receive timeout and saturating error count.
module proto_sequencer #(
   parameter int unsigned MAX_LEN     = 16,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic               in_clk,
   input  logic               in_rst,
   proto_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_OPC, S_ADDR, S_LEN, S_WDATA, S_RD_FETCH, S_RD_LATCH, S_TX_DATA, S_TX_STATUS
   } state_e;

   localparam logic [7:0]  OPC_WR    = 8'h01;
   localparam logic [7:0]  OPC_RD    = 8'h02;
   localparam logic [7:0]  ST_OK     = 8'hA5;
   localparam logic [7:0]  ST_ERR    = 8'hEE;
   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);

   state_e      state_q, state_d;
   logic        is_wr_q, is_wr_d;
   logic [7:0]  base_q, base_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  idx_q, idx_d;
   logic        rx_cont_q, rx_cont_d;
   logic        tx_cont_q, tx_cont_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic        rd_q, rd_d;
   logic [7:0]  err_q, err_d;
   logic [15:0] to_cnt_q, to_cnt_d;
   logic        err_inc;
   logic        in_rx_state;

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q   <= S_OPC;
         is_wr_q   <= 1'b0;
         base_q    <= 8'h00;
         len_q     <= 8'h00;
         idx_q     <= 8'h00;
         rx_cont_q <= 1'b0;
         tx_cont_q <= 1'b0;
         tx_data_q <= 8'h00;
         addr_q    <= 8'h00;
         wdata_q   <= 8'h00;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         err_q     <= 8'h00;
         to_cnt_q  <= 16'h0000;
      end else begin
         state_q   <= state_d;
         is_wr_q   <= is_wr_d;
         base_q    <= base_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         rx_cont_q <= rx_cont_d;
         tx_cont_q <= tx_cont_d;
         tx_data_q <= tx_data_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         err_q     <= err_d;
         to_cnt_q  <= to_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      is_wr_d   = is_wr_q;
      base_d    = base_q;
      len_d     = len_q;
      idx_d     = idx_q;
      rx_cont_d = rx_cont_q;
      tx_cont_d = tx_cont_q;
      tx_data_d = tx_data_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = 1'b0;
      rd_d      = 1'b0;
      err_d     = err_q;
      to_cnt_d  = 16'h0000;
      err_inc   = 1'b0;
      in_rx_state = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_WDATA);

      unique case (state_q)
         S_OPC: begin
            if (bus.rx_done) begin
               rx_cont_d = 1'b0;
               if (bus.in_rx_data == OPC_WR || bus.in_rx_data == OPC_RD) begin
                  is_wr_d = (bus.in_rx_data == OPC_WR);
                  state_d = S_ADDR;
               end else begin
                  state_d   = S_TX_STATUS;
                  tx_data_d = ST_ERR;
                  tx_cont_d = 1'b1;
                  err_inc   = 1'b1;
               end
            end
         end
         S_ADDR: begin
            if (bus.rx_done) begin
               rx_cont_d = 1'b0;
               base_d    = bus.in_rx_data;
               state_d   = S_LEN;
            end else begin
               rx_cont_d = 1'b1;
            end
         end
         S_LEN: begin
            if (bus.rx_done) begin
               rx_cont_d = 1'b0;
               len_d     = bus.in_rx_data;
               idx_d     = 8'h00;
               if (bus.in_rx_data == 8'h00 || bus.in_rx_data > MAX_LEN_B) begin
                  state_d   = S_TX_STATUS;
                  tx_data_d = ST_ERR;
                  tx_cont_d = 1'b1;
                  err_inc   = 1'b1;
               end else if (is_wr_q) begin
                  state_d = S_WDATA;
               end else begin
                  state_d = S_RD_FETCH;
                  addr_d  = base_q;
                  rd_d    = 1'b1;
               end
            end else begin
               rx_cont_d = 1'b1;
            end
         end
         S_WDATA: begin
            if (bus.rx_done) begin
               rx_cont_d = 1'b0;
               wr_d      = 1'b1;
               addr_d    = base_q + idx_q;
               wdata_d   = bus.in_rx_data;
               idx_d     = idx_q + 8'd1;
               if (idx_q == len_q - 8'd1) begin
                  state_d   = S_TX_STATUS;
                  tx_data_d = ST_OK;
                  tx_cont_d = 1'b1;
               end
            end else begin
               rx_cont_d = 1'b1;
            end
         end
         // reg_rd is high during S_RD_FETCH, so reg_rdata is valid in S_RD_LATCH
         S_RD_FETCH: state_d = S_RD_LATCH;
         S_RD_LATCH: begin
            tx_data_d = bus.reg_rdata;
            tx_cont_d = 1'b1;
            state_d   = S_TX_DATA;
         end
         S_TX_DATA: begin
            if (bus.tx_done) begin
               tx_cont_d = 1'b0;
               if (idx_q == len_q - 8'd1) begin
                  state_d   = S_OPC;
                  rx_cont_d = 1'b1;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  addr_d  = base_q + idx_q + 8'd1;
                  rd_d    = 1'b1;
                  state_d = S_RD_FETCH;
               end
            end
         end
         S_TX_STATUS: begin
            if (bus.tx_done) begin
               tx_cont_d = 1'b0;
               state_d   = S_OPC;
               rx_cont_d = 1'b1;
            end
         end
         default: state_d = S_OPC;
      endcase

      // Abandon a stalled frame; rx_continue stays high so the next opcode can arrive.
      if (in_rx_state && !bus.rx_done && rx_cont_q) begin
         if (to_cnt_q == TO_LAST) begin
            state_d   = S_OPC;
            rx_cont_d = 1'b1;
            err_inc   = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 16'd1;
         end
      end
      if (state_d != state_q) begin
         to_cnt_d = 16'h0000;
      end

      if (err_inc && err_q != 8'hFF) begin
         err_d = err_q + 8'd1;
      end
   end

   assign bus.rx_continue = rx_cont_q;
   assign bus.tx_continue = tx_cont_q;
   assign bus.out_tx_data = tx_data_q;
   assign bus.reg_addr    = addr_q;
   assign bus.reg_wdata   = wdata_q;
   assign bus.reg_wr      = wr_q;
   assign bus.reg_rd      = rd_q;
   assign bus.out_err_cnt = err_q;
   assign bus.out_busy    = (state_q != S_OPC);

endmodule

// File: tb/tb_proto_sequencer.sv
// Randomized scoreboard bench for proto_sequencer: a frame-level reference model queues
// expected register writes, reads and transmit bytes; a monitor pops and compares them.
module tb_proto_sequencer;

   localparam int MAX_LEN = 8;
   localparam int TIMEOUT = 40;

   logic in_clk = 1'b0;
   logic in_rst = 1'b1;

   proto_sequencer_if bus ();

   proto_sequencer #(
      .MAX_LEN     (MAX_LEN),
      .TIMEOUT_CYC (TIMEOUT)
   ) dut (
      .in_clk (in_clk),
      .in_rst (in_rst),
      .bus    (bus.master)
   );

   always #5 in_clk = ~in_clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [15:0] exp_wr[$];
   logic [7:0]  exp_rd[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  model_mem[256] = '{default: 8'h00};
   logic [7:0]  slave_mem[256] = '{default: 8'h00};
   int          model_err;
   logic [7:0]  fbuf[0:31];
   bit          tx_hold = 1'b0;
   bit          after_reset;
   bit          overlap_seen = 1'b0;
   bit          unstable_seen = 1'b0;
   bit          prev_txc = 1'b0;
   logic [7:0]  prev_tx = 8'h00;

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
   endfunction

   // Register file on the far side of the bus: read data appears the cycle after reg_rd.
   always @(posedge in_clk) begin
      if (in_rst) begin
         bus.reg_rdata <= 8'h00;
      end else begin
         if (bus.reg_wr) slave_mem[bus.reg_addr] <= bus.reg_wdata;
         if (bus.reg_rd) bus.reg_rdata <= slave_mem[bus.reg_addr];
      end
   end

   // Transmit front end: consumes a byte after a random delay unless held off.
   initial begin
      int dly;
      dly = -1;
      bus.tx_done = 1'b0;
      forever begin
         @(posedge in_clk);
         #1;
         bus.tx_done = 1'b0;
         if (bus.tx_continue && !tx_hold && !in_rst) begin
            if (dly < 0) dly = int'($urandom_range(0, 3));
            if (dly == 0) begin
               bus.tx_done = 1'b1;
               dly = -1;
            end else begin
               dly--;
            end
         end else begin
            dly = -1;
         end
      end
   end

   always @(negedge in_clk) begin
      if (!in_rst) begin
         if (bus.rx_continue && bus.tx_continue) overlap_seen = 1'b1;
         if (prev_txc && bus.tx_continue && bus.out_tx_data != prev_tx) unstable_seen = 1'b1;
         if (bus.reg_wr) begin
            if (exp_wr.size() == 0) chk("unexpected_reg_wr", 1, 0);
            else chk("reg_wr_addr_data", 32'({bus.reg_addr, bus.reg_wdata}),
                     32'(exp_wr.pop_front()));
         end
         if (bus.reg_rd) begin
            if (exp_rd.size() == 0) chk("unexpected_reg_rd", 1, 0);
            else chk("reg_rd_addr", 32'(bus.reg_addr), 32'(exp_rd.pop_front()));
         end
         if (bus.tx_done && bus.tx_continue) begin
            if (exp_tx.size() == 0) chk("unexpected_tx", 1, 0);
            else chk("tx_byte", 32'(bus.out_tx_data), 32'(exp_tx.pop_front()));
         end
      end
      prev_txc = bus.tx_continue;
      prev_tx  = bus.out_tx_data;
   end

   task automatic tick(int n);
      repeat (n) @(negedge in_clk);
   endtask

   task automatic wait_rx_cont();
      int k;
      k = 0;
      while (!bus.rx_continue && k < 300) begin
         @(negedge in_clk);
         k++;
      end
      chk("rx_continue_wait", 32'(bus.rx_continue), 1);
   endtask

   task automatic send_byte(logic [7:0] b, bit need_cont);
      if (need_cont) begin
         wait_rx_cont();
         tick(int'($urandom_range(0, 2)));
      end
      bus.in_rx_data = b;
      bus.rx_done    = 1'b1;
      @(negedge in_clk);
      bus.rx_done    = 1'b0;
      bus.in_rx_data = 8'($urandom);
   endtask

   function automatic void bump_err();
      if (model_err < 255) model_err++;
   endfunction

   task automatic frame3(logic [7:0] o, logic [7:0] a, logic [7:0] n);
      fbuf[0] = o;
      fbuf[1] = a;
      fbuf[2] = n;
   endtask

   // Reference model: decide the frame's outcome from its bytes, queue expectations, send it.
   task automatic run_frame();
      logic [7:0] opc, a, n, ad;
      int nsend;
      opc = fbuf[0];
      a   = fbuf[1];
      n   = fbuf[2];
      if (opc != 8'h01 && opc != 8'h02) begin
         exp_tx.push_back(8'hEE);
         bump_err();
         nsend = 1;
      end else if (n == 8'h00 || int'(n) > MAX_LEN) begin
         exp_tx.push_back(8'hEE);
         bump_err();
         nsend = 3;
      end else if (opc == 8'h01) begin
         for (int i = 0; i < int'(n); i++) begin
            ad = a + 8'(i);
            exp_wr.push_back({ad, fbuf[3+i]});
            model_mem[ad] = fbuf[3+i];
         end
         exp_tx.push_back(8'hA5);
         nsend = 3 + int'(n);
      end else begin
         for (int i = 0; i < int'(n); i++) begin
            ad = a + 8'(i);
            exp_rd.push_back(ad);
            exp_tx.push_back(model_mem[ad]);
         end
         nsend = 3;
      end
      for (int i = 0; i < nsend; i++) begin
         send_byte(fbuf[i], !(i == 0 && after_reset));
         after_reset = 1'b0;
      end
   endtask

   task automatic finish_frame();
      wait_rx_cont();
      chk("err_cnt", 32'(bus.out_err_cnt), 32'(model_err));
      chk("busy_idle", 32'(bus.out_busy), 0);
      chk("queues_drained", 32'(exp_wr.size() + exp_rd.size() + exp_tx.size()), 0);
   endtask

   initial begin
      int k;
      logic [7:0] a, n;
      int kind;
      bus.rx_done    = 1'b0;
      bus.in_rx_data = 8'h00;
      model_err      = 0;
      after_reset    = 1'b1;
      tick(3);
      in_rst = 1'b0;
      tick(1);
      chk("rst_rx_continue", 32'(bus.rx_continue), 0);
      chk("rst_tx_continue", 32'(bus.tx_continue), 0);
      chk("rst_reg_wr", 32'(bus.reg_wr), 0);
      chk("rst_reg_rd", 32'(bus.reg_rd), 0);
      chk("rst_tx_data", 32'(bus.out_tx_data), 0);
      chk("rst_reg_addr", 32'(bus.reg_addr), 0);
      chk("rst_reg_wdata", 32'(bus.reg_wdata), 0);
      chk("rst_err_cnt", 32'(bus.out_err_cnt), 0);
      chk("rst_busy", 32'(bus.out_busy), 0);

      // Basic write, then wrapping write and read-back across 0xFF -> 0x00
      frame3(8'h01, 8'h10, 8'h02); fbuf[3] = 8'hAA; fbuf[4] = 8'hBB;
      run_frame(); finish_frame();
      frame3(8'h01, 8'hFF, 8'h02); fbuf[3] = 8'h5A; fbuf[4] = 8'hC3;
      run_frame(); finish_frame();
      frame3(8'h02, 8'hFF, 8'h02);
      run_frame(); finish_frame();

      frame3(8'h7E, 8'h00, 8'h00);
      run_frame(); finish_frame();

      // Stall after the address byte
      bump_err();
      send_byte(8'h01, 1'b1);
      send_byte(8'h20, 1'b1);
      tick(TIMEOUT - 3);
      chk("no_early_timeout", 32'(bus.out_busy), 1);
      tick(10);
      chk("timeout_busy", 32'(bus.out_busy), 0);
      chk("timeout_err_cnt", 32'(bus.out_err_cnt), 32'(model_err));
      chk("timeout_rx_continue", 32'(bus.rx_continue), 1);
      frame3(8'h02, 8'h20, 8'h01);
      run_frame(); finish_frame();

      frame3(8'h02, 8'h30, 8'h00);
      run_frame(); finish_frame();
      frame3(8'h01, 8'h30, 8'(MAX_LEN + 1));
      run_frame(); finish_frame();
      frame3(8'h02, 8'hFC, 8'(MAX_LEN));
      run_frame(); finish_frame();

      // Reset while a read byte is waiting to be transmitted
      tx_hold = 1'b1;
      frame3(8'h02, 8'hFF, 8'h03);
      run_frame();
      k = 0;
      while (!bus.tx_continue && k < 20) begin
         tick(1);
         k++;
      end
      chk("tx_continue_reached", 32'(bus.tx_continue), 1);
      in_rst = 1'b1;
      #1;
      chk("mid_rst_tx_continue", 32'(bus.tx_continue), 0);
      chk("mid_rst_err_cnt", 32'(bus.out_err_cnt), 0);
      chk("mid_rst_busy", 32'(bus.out_busy), 0);
      chk("mid_rst_rx_continue", 32'(bus.rx_continue), 0);
      exp_wr.delete();
      exp_rd.delete();
      exp_tx.delete();
      model_err = 0;
      tick(1);
      in_rst      = 1'b0;
      tx_hold     = 1'b0;
      after_reset = 1'b1;
      frame3(8'h01, 8'h40, 8'h01); fbuf[3] = 8'h77;
      run_frame(); finish_frame();
      frame3(8'h02, 8'h40, 8'h01);
      run_frame(); finish_frame();

      for (int f = 0; f < 40; f++) begin
         kind = int'($urandom_range(0, 11));
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255))
                                         : 8'($urandom_range(0, 31));
         n = 8'($urandom_range(1, MAX_LEN));
         if (kind <= 5) begin
            frame3(8'h01, a, n);
            for (int i = 0; i < int'(n); i++) fbuf[3+i] = 8'($urandom);
         end else if (kind <= 9) begin
            frame3(8'h02, a, n);
         end else if (kind == 10) begin
            frame3(8'($urandom_range(3, 255)), a, n);
         end else begin
            n = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
            frame3(($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02, a, n);
         end
         run_frame();
         finish_frame();
      end

      chk("rx_tx_never_overlap", 32'(overlap_seen), 0);
      chk("tx_data_stable", 32'(unstable_seen), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_total);
      $fatal(1);
   end

endmodule
